// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Holds the opcode constants, boolean constants, state/select encodings,
// the packed control-output bundle and the legal-opcode check.
package multicycle_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned RD_W  = 5;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // RV32I base opcodes
  localparam logic [OPC_W-1:0] OPC_OP_I  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP_R  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_B  = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_OP_L  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_S  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,   // pc + 1
    PC_TARGET = 2'd1,   // pc + imm (taken branch, JAL)
    PC_JALR   = 2'd2    // rs1 + imm
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_RSVD = 2'd2
  } wb_sel_e;

  // Control bundle driven to the datapath each cycle
  typedef struct packed {
    logic    imem_req;
    logic    ir_we;
    logic    dmem_req;
    logic    dmem_we;
    logic    op1_sel;
    logic    op2_sel;
    logic    rf_we;
    wb_sel_e wb_sel;
    logic    pc_we;
    pc_sel_e pc_sel;
  } ctrl_t;

  // True for every opcode this core implements
  function automatic logic is_legal_opcode(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_OP_I, OPC_OP_R, OPC_OP_B, OPC_OP_L, OPC_OP_S,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: is_legal_opcode = TRUE;
      default:                               is_legal_opcode = FALSE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory handshake wait counter shared by the FETCH and MEM states.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - return the count to zero (takes priority over en)
//   en        - count one more waiting cycle
//   hit_c     - the current waiting cycle is the LIMIT-th one; 0 when LIMIT = 0
module multicycle_ctrl_mem_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit_c
);

  localparam int unsigned TW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on the stored count so the FSM can gate it with ready
  // without forming a combinational loop through en.
  assign hit_c = (LIMIT != 0) && (cnt_q == TW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB], steering the shared
// ALU operand muxes, IR/PC/register-file enables and memory requests.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   ir                    - latched instruction (opcode, rd decoded here)
//   imem_ready/dmem_ready - memory handshake completion
//   alu_out               - ALU result; bit 0 is branch-taken for OP_B
//   imem_req, ir_we, dmem_req, dmem_we, op1_sel, op2_sel, rf_we, wb_sel,
//   pc_we, pc_sel         - datapath controls (combinational from state/ir)
//   state                 - current FSM state for debug
//   trap                  - sticky fault flag
//   instret               - retired instruction count, wraps
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   ir,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   alu_out,
  output logic              imem_req,
  output logic              ir_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              op1_sel,
  output logic              op2_sel,
  output logic              rf_we,
  output logic [1:0]        wb_sel,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [2:0]        state,
  output logic              trap,
  output logic [CNT_W-1:0]  instret
);

  state_e             state_q, state_d;
  logic               trap_q, trap_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  ctrl_t              ctrl_c;
  logic               tmr_clr_c, tmr_en_c, tmr_hit_c;

  logic [OPC_W-1:0]   opcode;
  logic               rd_nz;
  logic               unused_bits;

  assign opcode = ir[OPC_W-1:0];
  assign rd_nz  = (ir[11:7] != RD_W'(0));

  // Function bits and upper ALU bits are decoded by the datapath, not here
  assign unused_bits = ^{ir[31:12], alu_out[XLEN-1:1]};

  multicycle_ctrl_mem_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr_c),
    .en    (tmr_en_c),
    .hit_c (tmr_hit_c)
  );

  // Next state, commit bookkeeping and datapath controls
  always_comb begin
    state_d   = state_q;
    trap_d    = trap_q;
    instret_d = instret_q;
    ctrl_c    = '0;
    tmr_en_c  = FALSE;
    tmr_clr_c = TRUE;

    unique case (state_q)
      ST_FETCH: begin
        ctrl_c.imem_req = TRUE;
        if (imem_ready) begin
          ctrl_c.ir_we = TRUE;
          state_d      = ST_DECODE;
        end else begin
          tmr_en_c  = TRUE;
          tmr_clr_c = FALSE;
          if (tmr_hit_c) state_d = ST_TRAP;
        end
      end

      ST_DECODE: begin
        state_d = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
      end

      ST_EXEC: begin
        ctrl_c.op1_sel = (opcode == OPC_AUIPC);
        ctrl_c.op2_sel = (opcode == OPC_OP_I) || (opcode == OPC_OP_L) ||
                         (opcode == OPC_OP_S) || (opcode == OPC_LUI) ||
                         (opcode == OPC_AUIPC);
        if ((opcode == OPC_OP_L) || (opcode == OPC_OP_S)) begin
          state_d = ST_MEM;
        end else if (opcode == OPC_OP_B) begin
          // Branch retires here; target chosen by the ALU compare flag
          ctrl_c.pc_we  = TRUE;
          ctrl_c.pc_sel = alu_out[0] ? PC_TARGET : PC_NEXT;
          instret_d     = instret_q + CNT_W'(1);
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        ctrl_c.dmem_req = TRUE;
        ctrl_c.dmem_we  = (opcode == OPC_OP_S);
        if (dmem_ready) begin
          if (opcode == OPC_OP_S) begin
            ctrl_c.pc_we  = TRUE;
            ctrl_c.pc_sel = PC_NEXT;
            instret_d     = instret_q + CNT_W'(1);
            state_d       = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          tmr_en_c  = TRUE;
          tmr_clr_c = FALSE;
          if (tmr_hit_c) state_d = ST_TRAP;
        end
      end

      ST_WB: begin
        ctrl_c.rf_we  = rd_nz;
        ctrl_c.wb_sel = (opcode == OPC_OP_L) ? WB_LOAD : WB_ALU;
        ctrl_c.pc_we  = TRUE;
        if (opcode == OPC_JAL) begin
          ctrl_c.pc_sel = PC_TARGET;
        end else if (opcode == OPC_JALR) begin
          ctrl_c.pc_sel = PC_JALR;
        end else begin
          ctrl_c.pc_sel = PC_NEXT;
        end
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_FETCH;
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_TRAP;
      end
    endcase

    if (state_d == ST_TRAP) trap_d = TRUE;

    // Nothing reaches the datapath while reset is applied
    if (rst) begin
      ctrl_c    = '0;
      tmr_en_c  = FALSE;
      tmr_clr_c = TRUE;
    end
  end

  // State, trap and retire counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      trap_q    <= FALSE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

  assign imem_req = ctrl_c.imem_req;
  assign ir_we    = ctrl_c.ir_we;
  assign dmem_req = ctrl_c.dmem_req;
  assign dmem_we  = ctrl_c.dmem_we;
  assign op1_sel  = ctrl_c.op1_sel;
  assign op2_sel  = ctrl_c.op2_sel;
  assign rf_we    = ctrl_c.rf_we;
  assign wb_sel   = ctrl_c.wb_sel;
  assign pc_we    = ctrl_c.pc_we;
  assign pc_sel   = ctrl_c.pc_sel;
  assign state    = state_q;
  assign trap     = trap_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl with WAIT_LIMIT = 4.
// Control vector bit order: {imem_req, ir_we, dmem_req, dmem_we, op1_sel,
// op2_sel, rf_we, wb_sel[1:0], pc_we, pc_sel[1:0]}.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 32;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_BEQ  = 32'h00208063; // beq x1,x2,0
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] I_SW   = 32'h0020A023; // sw  x2,0(x1)
  localparam logic [31:0] I_JAL  = 32'h000000EF; // jal x1,0
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  localparam logic [11:0] C_IDLE   = 12'b0000_0000_0000;
  localparam logic [11:0] C_FREQ   = 12'b1000_0000_0000;
  localparam logic [11:0] C_FETCH  = 12'b1100_0000_0000;
  localparam logic [11:0] C_EXIMM  = 12'b0000_0100_0000;
  localparam logic [11:0] C_WBALU  = 12'b0000_0010_0100;
  localparam logic [11:0] C_WBLD   = 12'b0000_0010_1100;
  localparam logic [11:0] C_WBJAL  = 12'b0000_0010_0101;
  localparam logic [11:0] C_BTAKE  = 12'b0000_0000_0101;
  localparam logic [11:0] C_BNOT   = 12'b0000_0000_0100;
  localparam logic [11:0] C_MEMLD  = 12'b0010_0000_0000;
  localparam logic [11:0] C_MEMST  = 12'b0011_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      ir;
  logic             imem_ready, dmem_ready;
  logic [31:0]      alu_out;
  logic             imem_req, ir_we, dmem_req, dmem_we, op1_sel, op2_sel;
  logic             rf_we, pc_we;
  logic [1:0]       wb_sel, pc_sel;
  logic [2:0]       state;
  logic             trap;
  logic [CNT_W-1:0] instret;
  logic [11:0]      ctrl_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .WAIT_LIMIT (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ir         (ir),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .alu_out    (alu_out),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .op1_sel    (op1_sel),
    .op2_sel    (op2_sel),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .state      (state),
    .trap       (trap),
    .instret    (instret)
  );

  assign ctrl_v = {imem_req, ir_we, dmem_req, dmem_we, op1_sel, op2_sel,
                   rf_we, wb_sel, pc_we, pc_sel};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle's state and controls, then advance past the next edge
  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] ctl);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctrl"},  32'(ctrl_v), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ir = I_ADD; imem_ready = 1'b0; dmem_ready = 1'b0; alu_out = '0;
    @(posedge clk); #1;
    cyc("reset", 3'd0, C_IDLE);
    check("reset.trap", 32'(trap), 32'd0);
    check("reset.instret", instret, 32'd0);
    rst = 1'b0;

    // ADD, zero-wait fetch: 0 -> 1 -> 2 -> 4
    imem_ready = 1'b1;
    cyc("add.f", 3'd0, C_FETCH);
    cyc("add.d", 3'd1, C_IDLE);
    cyc("add.e", 3'd2, C_IDLE);
    check("add.instret_pre", instret, 32'd0);
    cyc("add.w", 3'd4, C_WBALU);
    check("add.instret", instret, 32'd1);

    // BEQ taken then not taken, retiring in EXEC
    ir = I_BEQ; alu_out = 32'd1;
    cyc("beq1.f", 3'd0, C_FETCH);
    cyc("beq1.d", 3'd1, C_IDLE);
    cyc("beq1.e", 3'd2, C_BTAKE);
    check("beq1.instret", instret, 32'd2);
    alu_out = 32'd0;
    cyc("beq0.f", 3'd0, C_FETCH);
    cyc("beq0.d", 3'd1, C_IDLE);
    cyc("beq0.e", 3'd2, C_BNOT);
    check("beq0.instret", instret, 32'd3);

    // LW with dmem_ready on the 4th MEM cycle (also ready-at-limit wins)
    ir = I_LW;
    cyc("lw.f", 3'd0, C_FETCH);
    cyc("lw.d", 3'd1, C_IDLE);
    cyc("lw.e", 3'd2, C_EXIMM);
    for (int i = 0; i < 3; i++) cyc("lw.mwait", 3'd3, C_MEMLD);
    dmem_ready = 1'b1;
    cyc("lw.m", 3'd3, C_MEMLD);
    dmem_ready = 1'b0;
    cyc("lw.w", 3'd4, C_WBLD);
    check("lw.instret", instret, 32'd4);
    check("lw.trap", 32'(trap), 32'd0);

    // JAL writes rd and redirects to pc+imm
    ir = I_JAL;
    cyc("jal.f", 3'd0, C_FETCH);
    cyc("jal.d", 3'd1, C_IDLE);
    cyc("jal.e", 3'd2, C_IDLE);
    cyc("jal.w", 3'd4, C_WBJAL);
    check("jal.instret", instret, 32'd5);

    // Store interrupted by reset while in MEM
    ir = I_SW;
    cyc("sw.f", 3'd0, C_FETCH);
    cyc("sw.d", 3'd1, C_IDLE);
    cyc("sw.e", 3'd2, C_EXIMM);
    cyc("sw.m", 3'd3, C_MEMST);
    rst = 1'b1;
    cyc("sw.rst", 3'd3, C_IDLE);
    rst = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b0;
    check("sw.rst_instret", instret, 32'd0);
    check("sw.rst_trap", 32'(trap), 32'd0);

    // Fetch timeout: four waiting FETCH cycles then TRAP
    for (int i = 0; i < 4; i++) cyc("to.fwait", 3'd0, C_FREQ);
    imem_ready = 1'b1;
    cyc("to.trap1", 3'd5, C_IDLE);
    check("to.trap", 32'(trap), 32'd1);
    cyc("to.trap2", 3'd5, C_IDLE);
    check("to.instret", instret, 32'd0);

    // Reset out of TRAP, then ready arriving on the limit cycle wins
    rst = 1'b1;
    cyc("to.rst", 3'd5, C_IDLE);
    rst = 1'b0; imem_ready = 1'b0;
    check("to.rst_trap", 32'(trap), 32'd0);
    for (int i = 0; i < 3; i++) cyc("lim.fwait", 3'd0, C_FREQ);
    imem_ready = 1'b1; ir = I_ILL;
    cyc("lim.f", 3'd0, C_FETCH);
    check("lim.trap", 32'(trap), 32'd0);

    // Illegal opcode: DECODE -> TRAP, sticky, no commits
    dmem_ready = 1'b1;
    cyc("ill.d", 3'd1, C_IDLE);
    for (int i = 0; i < 3; i++) begin
      cyc("ill.trap", 3'd5, C_IDLE);
      check("ill.trapflag", 32'(trap), 32'd1);
    end
    check("ill.instret", instret, 32'd0);
    rst = 1'b1;
    cyc("ill.rst", 3'd5, C_IDLE);
    rst = 1'b0; imem_ready = 1'b0;
    cyc("ill.after", 3'd0, C_FREQ);
    check("ill.rst_trap", 32'(trap), 32'd0);
    check("ill.rst_instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I core.
- Sequences the shared ALU, IR, PC, register file and instruction/data memory ports through FETCH, DECODE, EXEC, MEM and WB.
- Decodes opcode/func3 from the latched IR, steers ALU operand muxes and PC/writeback selects, and resolves branches from the ALU result.
- Counts retired instructions. Traps on an illegal opcode or a memory handshake timeout.

Parameters:
- WAIT_LIMIT, 255: maximum cycles to wait for imem_ready/dmem_ready before trapping; 0 disables the timeout.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ir  in  32  instruction register contents (opcode = ir[6:0], func3 = ir[14:12], rd = ir[11:7])
- imem_ready  in  1  instruction fetch complete this cycle
- dmem_ready  in  1  data access complete this cycle
- alu_out  in  32  ALU result; bit 0 is the branch-taken flag for OP_B
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load IR from imem
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- op1_sel  out  1  0 = rs1, 1 = pc
- op2_sel  out  1  0 = rs2, 1 = immediate
- rf_we  out  1  register file write enable
- wb_sel  out  2  0 = alu_out, 1 = load data, 2 = reserved
- pc_we  out  1  PC update enable
- pc_sel  out  2  0 = pc+1, 1 = pc+imm (branch/JAL), 2 = rs1+imm (JALR)
- state  out  3  current state, for debug
- trap  out  1  sticky fault flag
- instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - state = FETCH; trap = 0; instret = 0; wait counter = 0.
  - In the reset cycle all enables and requests are 0.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Registered: state, wait counter, trap, instret.
- Combinational: outputs, decoded from state, ir and the ready inputs.
- FETCH:
  - imem_req = 1.
  - When imem_ready = 1: ir_we = 1, go to DECODE, wait counter cleared.
  - Otherwise the wait counter increments.
- DECODE: the register file read settles.
  - Opcode in {OP_I, OP_R, OP_B, OP_L, OP_S, LUI, AUIPC, JAL, JALR}: go to EXEC.
  - Any other opcode: go to TRAP.
- EXEC: operand selects are held.
  - op1_sel = 1 only for AUIPC.
  - op2_sel = 1 for OP_I, OP_L, OP_S, LUI, AUIPC.
  - OP_L / OP_S: go to MEM.
  - OP_B: pc_we = 1; pc_sel = 1 if alu_out[0] = 1, else 0; instret += 1; go to FETCH.
  - All other legal opcodes: go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for OP_S.
  - Hold until dmem_ready = 1.
  - Store completes: pc_we = 1, pc_sel = 0, instret += 1, go to FETCH.
  - Load completes: go to WB.
- WB:
  - rf_we = 1 when rd != 0; wb_sel = 1 for OP_L, else 0. JAL/JALR write alu_out, which equals pc+1.
  - pc_we = 1; pc_sel = 1 for JAL, 2 for JALR, else 0.
  - instret += 1; go to FETCH.
- Timeout:
  - In FETCH or MEM with ready = 0, the wait counter increments.
  - When it reaches WAIT_LIMIT (WAIT_LIMIT > 0): go to TRAP, no commit.
  - A ready arriving in the same cycle as the limit wins: the transfer completes, no trap.
- TRAP:
  - trap = 1; all enables and requests 0.
  - Absorbing; only rst leaves it.
- Latency in cycles, zero-wait memory:
  - OP_R / OP_I / LUI / AUIPC / JAL / JALR: 4.
  - Load: 5.
  - Store and branch: 4 and 3 respectively.
- instret wraps modulo 2^CNT_W.
- Exactly one pc_we pulse per retired instruction; none for a trapped instruction.

Decomposition:
- const.svh (shared): opcode, func3 and TRUE/FALSE constants, plus new state encodings, pc_sel/wb_sel encodings and a LEGAL_OPCODE check macro.
- Sub-module mem_wait_timer: wait counter with clear, enable and limit-hit output, instantiated once and shared by FETCH and MEM.

Test Plan:
- ADD x3,x1,x2, zero-wait imem: states 0→1→2→4→0; rf_we = 1 and pc_we = 1 only in cycle 4; instret 0→1.
- BEQ with alu_out = 1 → pc_sel = 1 in EXEC (cycle 3); with alu_out = 0 → pc_sel = 0; rf_we stays 0; instret += 1.
- LW with dmem_ready delayed 3 cycles: MEM held 4 cycles with dmem_req = 1, dmem_we = 0; then WB with wb_sel = 1; total 8 cycles.
- Illegal opcode 7'h7F: DECODE→TRAP; trap = 1 sticky; no pc_we/rf_we; rst→FETCH with trap = 0 and instret = 0.
- WAIT_LIMIT = 4, imem_ready never asserted → TRAP after 4 FETCH cycles; repeated with ready on cycle 4 → no trap.
- rst asserted during MEM of a store → next cycle FETCH, dmem_req = 0, instret = 0, no PC update.
